oam_dma_ctrl: RTL

- Sprite-DMA engine that sits directly upstream of the PPU top level.
- On a CPU write of page number P to the DMA register, it halts the CPU. It then copies CPU memory P00h–PFFh into PPU sprite OAM through the PPU's oam_dma / oam_addr / oam_data_in write port.
- It releases the CPU when the copy is complete.
- It has real sequential behaviour: an FSM, a byte counter, cycle-parity alignment and a memory read/write handshake.

---
 rtl/oam_dma_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA engine: a CPU write of page P to DMA_REG_ADDR stalls the CPU and
// copies CPU memory P00h-PFFh into PPU OAM, one read/write pair per byte.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter int          NUM_BYTES    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic [7:0]  oam_start_addr,
    input  logic [7:0]  mem_data_in,
    output logic        cpu_stall,
    output logic        dma_mem_rd,
    output logic [15:0] dma_mem_addr,
    output logic        oam_dma,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data_in,
    output logic        dma_done,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic [7:0] base_q, base_d;
    logic       parity_q;

    logic trigger;
    logic in_read;
    logic in_write;

    assign trigger  = cpu_wr && (cpu_addr == DMA_REG_ADDR);
    assign in_read  = (state_q == S_READ);
    assign in_write = (state_q == S_WRITE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        base_d  = base_q;
        case (state_q)
            S_IDLE: begin
                // Triggers are only honoured here; a transfer cannot be restarted.
                if (trigger) begin
                    page_d  = cpu_data_in;
                    base_d  = oam_start_addr;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end
            S_HALT:  state_d = parity_q ? S_ALIGN : S_READ;
            S_ALIGN: state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 8'h00;
            page_q   <= 8'h00;
            base_q   <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            page_q   <= page_d;
            base_q   <= base_d;
            parity_q <= ~parity_q;
        end
    end

    assign cpu_stall    = (state_q != S_IDLE);
    assign dma_mem_rd   = in_read;
    assign dma_mem_addr = in_read ? {page_q, idx_q} : 16'h0000;
    assign oam_dma      = in_write;
    // OAM address wraps within 8 bits when base is non-zero.
    assign oam_addr     = in_write ? (base_q + idx_q) : 8'h00;
    assign oam_data_in  = in_write ? mem_data_in : 8'h00;
    assign dma_done     = in_write && (idx_q == LAST_IDX);
    assign dbg_state    = state_q;

endmodule
